mc_pred_sequencer: RTL and testbench

Parametrised prediction-output sequencer between the luma/chroma interpolators and the TQ stage. It accepts luma write beats and wider CbCr write beats, splits chroma beats into output-width beats, and buffers them in a small FIFO. Beats are sent to TQ over a valid/ready handshake with backpressure, so TQ may stall, unlike the fixed-timing ready pulse of the previous generation. It counts beats per macroblock and raises a done pulse after the last beat of the macroblock is accepted.

---
 rtl/mc_pkg.sv | 25 ++
 rtl/mc_pred_fifo.sv | 60 ++++++
 rtl/mc_pred_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_mc_pred_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the MC prediction-output sequencer.
// Contents: default pixel bit depth, FSM state encoding, chroma address base and
// per-macroblock beat total helpers.
package mc_pkg;

    localparam int unsigned BIT_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Chroma beats are addressed directly after the luma beats.
    function automatic int unsigned chroma_base(input int unsigned luma_beats);
        return luma_beats;
    endfunction

    function automatic int unsigned total_beats(input int unsigned luma_beats,
                                                input int unsigned chroma_writes,
                                                input int unsigned split);
        return luma_beats + chroma_writes * split;
    endfunction

endpackage

// File: rtl/mc_pred_fifo.sv
// Synchronous FIFO holding {addr, pixels} prediction beats.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          synchronous flush (pointers and count to zero)
//   push_i/wdata_i write one entry (ignored when full unless popping)
//   pop_i          drop the head entry (ignored when empty)
//   count_o        number of stored entries (pre-pop)
//   head_o         oldest entry
module mc_pred_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [WIDTH-1:0]             head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // Pointer increment that wraps for non power-of-two depths too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: the head is only observed while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mc_pred_sequencer.sv
// Prediction-output sequencer: collects luma beats and wide CbCr beats, splits chroma
// into output-width slices, buffers them and streams them to TQ over valid/ready.
// Raises done_o one cycle after the last beat of a macroblock is accepted.
// Optional build macro: MC_PRED_ORDER_CHK_EN enables per-MB write-order checking.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i / done_o    MB start pulse / MB completion pulse
//   err_o               sticky error (drops, collisions, order), cleared by start_i
//   in_ready_o          upstream may write this cycle
//   luma_*_i            luma write strobe, beat index, pixels
//   chroma_*_i, cbcr_*  chroma write strobe, write index, pixels (low slice first)
//   pred_*              output beat stream to TQ
module mc_pred_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned BIT_DEPTH     = BIT_DEPTH_DEF,
    parameter int unsigned OUT_PIX       = 32,
    parameter int unsigned LUMA_PIX      = 32,
    parameter int unsigned CHROMA_PIX    = 64,
    parameter int unsigned LUMA_BEATS    = 8,
    parameter int unsigned CHROMA_WRITES = 2,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned ADDR_W        = 4,
    localparam int unsigned CW_W = (CHROMA_WRITES > 1) ? $clog2(CHROMA_WRITES) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    output logic                            done_o,
    output logic                            err_o,
    output logic                            in_ready_o,
    input  logic                            luma_wren_i,
    input  logic [ADDR_W-1:0]               luma_wraddr_i,
    input  logic [LUMA_PIX*BIT_DEPTH-1:0]   luma_wrdata_i,
    input  logic                            chroma_wren_i,
    input  logic [CW_W-1:0]                 chroma_wraddr_i,
    input  logic [CHROMA_PIX*BIT_DEPTH-1:0] cbcr_wrdata_i,
    output logic                            pred_valid_o,
    input  logic                            pred_ready_i,
    output logic [OUT_PIX*BIT_DEPTH-1:0]    pred_data_o,
    output logic [ADDR_W-1:0]               pred_addr_o
);

    localparam int unsigned SPLIT  = CHROMA_PIX / OUT_PIX;
    localparam int unsigned TOTAL  = total_beats(LUMA_BEATS, CHROMA_WRITES, SPLIT);
    localparam int unsigned OUT_W  = OUT_PIX * BIT_DEPTH;
    localparam int unsigned CHR_W  = CHROMA_PIX * BIT_DEPTH;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OCNT_W = $clog2(TOTAL + 1);
    localparam int unsigned SL_W   = $clog2(SPLIT + 1);

    state_e              state_q, state_d;
    logic [CHR_W-1:0]    split_data_q, split_data_d;
    logic [ADDR_W-1:0]   split_addr_q, split_addr_d;
    logic [SL_W-1:0]     split_left_q, split_left_d;
    logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0]        fifo_count;
    logic [ADDR_W+OUT_W-1:0] fifo_head;
    logic [ADDR_W+OUT_W-1:0] push_data;
    logic                    push, fifo_clr, fire, split_busy, in_ready;
    logic                    luma_acc, chroma_acc, drop, order_err;
    logic [ADDR_W-1:0]       chroma_addr0;

    assign split_busy = (split_left_q != '0);
    // Conservative: free space is judged on the pre-pop count.
    assign in_ready   = (state_q == StRun) && !split_busy &&
                        (fifo_count <= CNT_W'(DEPTH - SPLIT));
    assign luma_acc   = luma_wren_i && in_ready;
    assign chroma_acc = chroma_wren_i && !luma_wren_i && in_ready;
    assign drop       = ((luma_wren_i || chroma_wren_i) && !in_ready) ||
                        (luma_wren_i && chroma_wren_i);
    assign chroma_addr0 = ADDR_W'(chroma_base(LUMA_BEATS)) +
                          ADDR_W'(chroma_wraddr_i) * ADDR_W'(SPLIT);
    assign pred_valid_o = (fifo_count != '0);
    assign fire         = pred_valid_o && pred_ready_i;

    // Slice 0 is pushed straight from the input; the split register feeds the rest.
    always_comb begin
        push         = 1'b0;
        push_data    = '0;
        split_data_d = split_data_q;
        split_addr_d = split_addr_q;
        split_left_d = split_left_q;
        if (split_busy) begin
            push         = 1'b1;
            push_data    = {split_addr_q, split_data_q[OUT_W-1:0]};
            split_data_d = split_data_q >> OUT_W;
            split_addr_d = split_addr_q + ADDR_W'(1);
            split_left_d = split_left_q - SL_W'(1);
        end else if (luma_acc) begin
            push      = 1'b1;
            push_data = {luma_wraddr_i, OUT_W'(luma_wrdata_i)};
        end else if (chroma_acc) begin
            push         = 1'b1;
            push_data    = {chroma_addr0, cbcr_wrdata_i[OUT_W-1:0]};
            split_data_d = cbcr_wrdata_i >> OUT_W;
            split_addr_d = chroma_addr0 + ADDR_W'(1);
            split_left_d = SL_W'(SPLIT - 1);
        end
        if (fifo_clr) split_left_d = '0;
    end

    always_comb begin
        state_d   = state_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q | drop | order_err;
        fifo_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRun;
                    fifo_clr  = 1'b1;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            StRun: begin
                if (fire) begin
                    out_cnt_d = out_cnt_q + OCNT_W'(1);
                    if (out_cnt_q == OCNT_W'(TOTAL - 1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            split_data_q <= '0;
            split_addr_q <= '0;
            split_left_q <= '0;
            out_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            split_data_q <= split_data_d;
            split_addr_q <= split_addr_d;
            split_left_q <= split_left_d;
            out_cnt_q    <= out_cnt_d;
            err_q        <= err_d;
        end
    end

`ifdef MC_PRED_ORDER_CHK_EN
    // Expected next indices; one extra bit so an overrun cannot alias back to zero.
    logic [ADDR_W:0] luma_exp_q, luma_exp_d;
    logic [CW_W:0]   chroma_exp_q, chroma_exp_d;

    assign order_err =
        (luma_acc && (({1'b0, luma_wraddr_i} != luma_exp_q) ||
                      (luma_exp_q >= (ADDR_W+1)'(LUMA_BEATS)))) ||
        (chroma_acc && (({1'b0, chroma_wraddr_i} != chroma_exp_q) ||
                        (luma_exp_q != (ADDR_W+1)'(LUMA_BEATS))));

    always_comb begin
        luma_exp_d   = luma_exp_q;
        chroma_exp_d = chroma_exp_q;
        if (fifo_clr) begin
            luma_exp_d   = '0;
            chroma_exp_d = '0;
        end else begin
            if (luma_acc)   luma_exp_d   = luma_exp_q + (ADDR_W+1)'(1);
            if (chroma_acc) chroma_exp_d = chroma_exp_q + (CW_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            luma_exp_q   <= '0;
            chroma_exp_q <= '0;
        end else begin
            luma_exp_q   <= luma_exp_d;
            chroma_exp_q <= chroma_exp_d;
        end
    end
`else
    assign order_err = 1'b0;
`endif

    mc_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + OUT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (fifo_clr),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (fire),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign pred_data_o = pred_valid_o ? fifo_head[OUT_W-1:0] : '0;
    assign pred_addr_o = pred_valid_o ? fifo_head[ADDR_W+OUT_W-1:OUT_W] : '0;
    assign in_ready_o  = in_ready;
    assign done_o      = (state_q == StDone);
    assign err_o       = err_q;

endmodule

// File: tb/tb_mc_pred_sequencer.sv
module tb_mc_pred_sequencer;

    localparam int TOTAL = 12;

    typedef struct packed {
        logic [3:0]   addr;
        logic [255:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         done_o, err_o, in_ready_o;
    logic         luma_wren_i = 1'b0;
    logic [3:0]   luma_wraddr_i = '0;
    logic [255:0] luma_wrdata_i = '0;
    logic         chroma_wren_i = 1'b0;
    logic [0:0]   chroma_wraddr_i = '0;
    logic [511:0] cbcr_wrdata_i = '0;
    logic         pred_valid_o;
    logic         pred_ready_i = 1'b1;
    logic [255:0] pred_data_o;
    logic [3:0]   pred_addr_o;

    int    total = 0;
    int    bad = 0;
    int    done_seen = 0;
    bit    mon_en = 1'b0;
    bit    prev_last = 1'b0;
    beat_t exp_q[$];

    mc_pred_sequencer dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .done_o          (done_o),
        .err_o           (err_o),
        .in_ready_o      (in_ready_o),
        .luma_wren_i     (luma_wren_i),
        .luma_wraddr_i   (luma_wraddr_i),
        .luma_wrdata_i   (luma_wrdata_i),
        .chroma_wren_i   (chroma_wren_i),
        .chroma_wraddr_i (chroma_wraddr_i),
        .cbcr_wrdata_i   (cbcr_wrdata_i),
        .pred_valid_o    (pred_valid_o),
        .pred_ready_i    (pred_ready_i),
        .pred_data_o     (pred_data_o),
        .pred_addr_o     (pred_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] luma_pat(input logic [15:0] seed, input logic [7:0] i);
        return {8{seed, 8'h00, i}};
    endfunction

    function automatic logic [511:0] chroma_pat(input logic [15:0] seed, input logic [7:0] w);
        return {{8{seed, 8'hC1, w}}, {8{seed, 8'hC0, w}}};
    endfunction

    // Monitor: pops the scoreboard on every transfer, checks zeroing and done timing.
    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            chk("done_timing", {259'd0, done_o}, {259'd0, prev_last});
            if (done_o) done_seen++;
            if (pred_valid_o && pred_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got addr %0d expected no beat", pred_addr_o);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", {pred_addr_o, pred_data_o}, {e.addr, e.data});
                end
                prev_last = (pred_addr_o == 4'(TOTAL - 1));
            end else begin
                prev_last = 1'b0;
            end
            if (!pred_valid_o) chk("idle_zero", {pred_addr_o, pred_data_o}, '0);
        end else begin
            prev_last = 1'b0;
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = in_ready_o;
        if (!ok) chk("in_ready_timeout", {259'd0, in_ready_o}, 260'd1);
    endtask

    task automatic luma_wr(input logic [3:0] a, input logic [255:0] d);
        bit ok;
        wait_ready(ok);
        luma_wren_i   = 1'b1;
        luma_wraddr_i = a;
        luma_wrdata_i = d;
        if (ok) exp_q.push_back('{addr: a, data: d});
        @(posedge clk);
        #1;
        luma_wren_i = 1'b0;
    endtask

    task automatic chroma_wr(input logic [0:0] w, input logic [511:0] d);
        bit ok;
        wait_ready(ok);
        chroma_wren_i   = 1'b1;
        chroma_wraddr_i = w;
        cbcr_wrdata_i   = d;
        if (ok) begin
            exp_q.push_back('{addr: 4'(8 + 2 * w), data: d[255:0]});
            exp_q.push_back('{addr: 4'(9 + 2 * w), data: d[511:256]});
        end
        @(posedge clk);
        #1;
        chroma_wren_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_seen == d0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 260'(done_seen - d0), 260'd1);
        chk("sb_empty", 260'(exp_q.size()), 260'd0);
    endtask

    task automatic run_mb(input logic [15:0] seed);
        int d0 = done_seen;
        pulse_start();
        for (int i = 0; i < 8; i++) luma_wr(4'(i), luma_pat(seed, 8'(i)));
        for (int w = 0; w < 2; w++) chroma_wr(1'(w), chroma_pat(seed, 8'(w)));
        wait_done(d0);
        chk("err_clean", {259'd0, err_o}, 260'd0);
    endtask

    initial begin
        int  d0;
        bit  exp_order_err;
        logic [259:0] held;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {259'd0, pred_valid_o}, 260'd0);
        chk("rst_data", {pred_addr_o, pred_data_o}, 260'd0);
        chk("rst_flags", {257'd0, done_o, err_o, in_ready_o}, 260'd0);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic MB with TQ always ready
        run_mb(16'hA001);

        // TQ stall for 20 cycles, upstream honours in_ready_o
        pred_ready_i = 1'b0;
        d0 = done_seen;
        pulse_start();
        fork
            begin
                for (int i = 0; i < 8; i++) luma_wr(4'(i), luma_pat(16'hB002, 8'(i)));
                for (int w = 0; w < 2; w++) chroma_wr(1'(w), chroma_pat(16'hB002, 8'(w)));
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("stall_in_ready", {259'd0, in_ready_o}, 260'd0);
                chk("stall_valid", {259'd0, pred_valid_o}, 260'd1);
                held = {pred_addr_o, pred_data_o};
                repeat (9) @(posedge clk);
                #1;
                chk("stall_hold", {pred_addr_o, pred_data_o}, held);
                chk("stall_head", {pred_addr_o, pred_data_o}, {4'd0, luma_pat(16'hB002, 8'd0)});
                pred_ready_i = 1'b1;
            end
        join
        wait_done(d0);
        chk("stall_err", {259'd0, err_o}, 260'd0);

        // Chroma write while in_ready_o is low is dropped
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < 8; i++) luma_wr(4'(i), luma_pat(16'hC003, 8'(i)));
        chroma_wr(1'b0, chroma_pat(16'hC003, 8'd0));
        chk("drop_in_ready", {259'd0, in_ready_o}, 260'd0);
        chroma_wren_i   = 1'b1;
        chroma_wraddr_i = 1'b1;
        cbcr_wrdata_i   = chroma_pat(16'hC003, 8'd1);
        @(posedge clk);
        #1;
        chroma_wren_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("drop_err", {259'd0, err_o}, 260'd1);
        chk("drop_no_done", 260'(done_seen - d0), 260'd0);
        chk("drop_sb_empty", 260'(exp_q.size()), 260'd0);
        pulse_start();
        chk("drop_err_sticky", {259'd0, err_o}, 260'd1);
        do_reset();

        // Luma and chroma in the same cycle
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < 7; i++) luma_wr(4'(i), luma_pat(16'hD004, 8'(i)));
        begin
            bit ok;
            wait_ready(ok);
            luma_wren_i     = 1'b1;
            luma_wraddr_i   = 4'd7;
            luma_wrdata_i   = luma_pat(16'hD004, 8'd7);
            chroma_wren_i   = 1'b1;
            chroma_wraddr_i = 1'b0;
            cbcr_wrdata_i   = chroma_pat(16'hDEAD, 8'd9);
            if (ok) exp_q.push_back('{addr: 4'd7, data: luma_pat(16'hD004, 8'd7)});
            @(posedge clk);
            #1;
            luma_wren_i   = 1'b0;
            chroma_wren_i = 1'b0;
        end
        chk("collide_err", {259'd0, err_o}, 260'd1);
        for (int w = 0; w < 2; w++) chroma_wr(1'(w), chroma_pat(16'hD004, 8'(w)));
        wait_done(d0);
        chk("collide_err_kept", {259'd0, err_o}, 260'd0 | 260'd1);

        // Out-of-order luma addresses
`ifdef MC_PRED_ORDER_CHK_EN
        exp_order_err = 1'b1;
`else
        exp_order_err = 1'b0;
`endif
        pulse_start();
        luma_wr(4'd0, luma_pat(16'hE005, 8'd0));
        luma_wr(4'd2, luma_pat(16'hE005, 8'd2));
        repeat (5) @(posedge clk);
        #1;
        chk("order_err", {259'd0, err_o}, {259'd0, exp_order_err});
        chk("order_sb_empty", 260'(exp_q.size()), 260'd0);
        do_reset();

        // Reset with three beats buffered
        pulse_start();
        pred_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) luma_wr(4'(i), luma_pat(16'hF006, 8'(i)));
        chk("pre_rst_valid", {259'd0, pred_valid_o}, 260'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", {259'd0, pred_valid_o}, 260'd0);
        chk("mid_rst_data", {pred_addr_o, pred_data_o}, 260'd0);
        chk("mid_rst_flags", {257'd0, done_o, err_o, in_ready_o}, 260'd0);
        rst_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("post_rst_idle", {259'd0, in_ready_o}, 260'd0);
        pred_ready_i = 1'b1;
        run_mb(16'h1707);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
